// File: rtl/thr_intr_lat_mon.sv
// Per-core thread interrupt latency monitor: checks that nukes reach DEAD and
// resumes leave DEAD within a runtime timeout, and tracks worst nuke latency.
module thr_intr_lat_mon #(
    parameter int            NTHR       = 4,
    parameter int            TIDW       = 2,
    parameter int            SW         = 5,
    parameter logic [SW-1:0] DEAD_ST    = '0,
    parameter int            CNTW       = 12,
    parameter bit            RESUME_CHK = 1'b1
) (
    input  logic               clk,
    input  logic               rst_l,
    input  logic               enable,
    input  logic [CNTW-1:0]    max_wait,
    input  logic               nukeint,
    input  logic               resumint,
    input  logic               rstint,
    input  logic [NTHR-1:0]    rstthr,
    input  logic [NTHR*SW-1:0] thr_state,
    output logic               err_vld,
    output logic [TIDW-1:0]    err_thr,
    output logic               err_type,
    output logic [NTHR-1:0]    err_sticky,
    output logic [7:0]         err_cnt,
    output logic [NTHR-1:0]    pend,
    output logic [CNTW-1:0]    max_lat
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_DEAD,
        ST_WAIT_LIVE
    } state_t;

    state_t          st_q  [NTHR];
    state_t          st_d  [NTHR];
    logic [CNTW-1:0] cnt_q [NTHR];
    logic [CNTW-1:0] cnt_d [NTHR];
    logic [CNTW-1:0] inc   [NTHR];

    logic [NTHR-1:0] tgt;
    logic [NTHR-1:0] dead;
    logic [NTHR-1:0] tmo;
    logic [NTHR-1:0] fail;
    logic [NTHR-1:0] ftype;
    logic [NTHR-1:0] hit;

    logic [CNTW-1:0] lat_d;
    logic [7:0]      nfail;
    logic [8:0]      ecnt_sum;
    logic [7:0]      ecnt_d;
    logic [TIDW-1:0] fthr;
    logic            ftyp;
    logic            found;

    // Lowest set bit of rstthr is the only thread a strobe can address.
    assign tgt = rstthr & (~rstthr + NTHR'(1));

    always_comb begin
        for (int i = 0; i < NTHR; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            fail[i]  = 1'b0;
            ftype[i] = 1'b0;
            hit[i]   = 1'b0;
            dead[i]  = (thr_state[i*SW +: SW] == DEAD_ST);
            // inc is also the elapsed cycle count since the strobe edge
            inc[i]   = (&cnt_q[i]) ? cnt_q[i] : cnt_q[i] + 1'b1;
            tmo[i]   = (max_wait != '0) && (inc[i] == max_wait);

            case (st_q[i])
                ST_WAIT_DEAD: begin
                    if (dead[i]) begin
                        st_d[i] = ST_IDLE;
                        hit[i]  = 1'b1;
                    end else if (tmo[i]) begin
                        st_d[i] = ST_IDLE;
                        fail[i] = 1'b1;
                    end else begin
                        cnt_d[i] = inc[i];
                    end
                end
                ST_WAIT_LIVE: begin
                    if (!dead[i]) begin
                        st_d[i] = ST_IDLE;
                    end else if (tmo[i]) begin
                        st_d[i]  = ST_IDLE;
                        fail[i]  = 1'b1;
                        ftype[i] = 1'b1;
                    end else begin
                        cnt_d[i] = inc[i];
                    end
                end
                ST_IDLE: ;
                default: st_d[i] = ST_IDLE;
            endcase

            // Strobes override wait evaluation and cancel a pending error.
            if (tgt[i]) begin
                if (rstint) begin
                    st_d[i]  = ST_IDLE;
                    cnt_d[i] = '0;
                    fail[i]  = 1'b0;
                end else if (resumint) begin
                    st_d[i]  = (RESUME_CHK && dead[i]) ? ST_WAIT_LIVE : ST_IDLE;
                    cnt_d[i] = '0;
                    fail[i]  = 1'b0;
                end else if (nukeint && st_q[i] != ST_WAIT_DEAD) begin
                    st_d[i]  = ST_WAIT_DEAD;
                    cnt_d[i] = '0;
                    fail[i]  = 1'b0;
                end
            end
        end

        lat_d = max_lat;
        nfail = '0;
        fthr  = '0;
        ftyp  = 1'b0;
        found = 1'b0;
        for (int i = 0; i < NTHR; i++) begin
            if (hit[i] && inc[i] > lat_d) lat_d = inc[i];
            if (fail[i]) begin
                nfail = nfail + 8'd1;
                if (!found) begin
                    found = 1'b1;
                    fthr  = TIDW'(i);
                    ftyp  = ftype[i];
                end
            end
        end
        ecnt_sum = {1'b0, err_cnt} + {1'b0, nfail};
        ecnt_d   = ecnt_sum[8] ? 8'hFF : ecnt_sum[7:0];
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            for (int i = 0; i < NTHR; i++) begin
                st_q[i]  <= ST_IDLE;
                cnt_q[i] <= '0;
            end
            err_vld    <= 1'b0;
            err_thr    <= '0;
            err_type   <= 1'b0;
            err_sticky <= '0;
            err_cnt    <= '0;
            max_lat    <= '0;
        end else begin
            for (int i = 0; i < NTHR; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
            max_lat <= lat_d;
            err_vld <= enable && (|fail);
            if (enable && (|fail)) begin
                err_thr    <= fthr;
                err_type   <= ftyp;
                err_sticky <= err_sticky | fail;
                err_cnt    <= ecnt_d;
            end
        end
    end

    always_comb begin
        pend = '0;
        for (int i = 0; i < NTHR; i++) pend[i] = (st_q[i] != ST_IDLE);
    end

endmodule

// File: tb/tb_thr_intr_lat_mon.sv
// Scoreboard bench for thr_intr_lat_mon: expected error pulses are queued by
// the stimulus and popped by a negedge monitor; status outputs checked inline.
module tb_thr_intr_lat_mon;

    localparam int NTHR = 4;
    localparam int TIDW = 2;
    localparam int SW   = 5;
    localparam int CNTW = 12;

    logic               clk = 1'b0;
    logic               rst_l;
    logic               enable;
    logic [CNTW-1:0]    max_wait;
    logic               nukeint;
    logic               resumint;
    logic               rstint;
    logic [NTHR-1:0]    rstthr;
    logic [NTHR*SW-1:0] thr_state;
    logic               err_vld;
    logic [TIDW-1:0]    err_thr;
    logic               err_type;
    logic [NTHR-1:0]    err_sticky;
    logic [7:0]         err_cnt;
    logic [NTHR-1:0]    pend;
    logic [CNTW-1:0]    max_lat;

    logic [NTHR-1:0]    dead_mask;
    logic [2:0]         exp_q[$];
    int                 total = 0;
    int                 bad   = 0;

    thr_intr_lat_mon #(
        .NTHR(NTHR), .TIDW(TIDW), .SW(SW), .DEAD_ST(5'h0),
        .CNTW(CNTW), .RESUME_CHK(1'b1)
    ) dut (
        .clk(clk), .rst_l(rst_l), .enable(enable), .max_wait(max_wait),
        .nukeint(nukeint), .resumint(resumint), .rstint(rstint),
        .rstthr(rstthr), .thr_state(thr_state),
        .err_vld(err_vld), .err_thr(err_thr), .err_type(err_type),
        .err_sticky(err_sticky), .err_cnt(err_cnt), .pend(pend),
        .max_lat(max_lat)
    );

    always #5 clk = ~clk;

    always_comb begin
        thr_state = '0;
        for (int i = 0; i < NTHR; i++)
            thr_state[i*SW +: SW] = dead_mask[i] ? 5'h00 : 5'h03;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every error pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_l === 1'b1 && err_vld === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_err: thr=%0d type=%0d expected none",
                         err_thr, err_type);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                chk("err_thr", 32'(err_thr), 32'(e[2:1]));
                chk("err_type", 32'(err_type), 32'(e[0]));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic n, input logic r, input logic x,
                          input logic [NTHR-1:0] thr);
        nukeint  = n;
        resumint = r;
        rstint   = x;
        rstthr   = thr;
        cyc();
        nukeint  = 1'b0;
        resumint = 1'b0;
        rstint   = 1'b0;
        rstthr   = '0;
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_err_vld"}, 32'(err_vld), 32'd0);
        chk({tag, "_err_thr"}, 32'(err_thr), 32'd0);
        chk({tag, "_err_type"}, 32'(err_type), 32'd0);
        chk({tag, "_sticky"}, 32'(err_sticky), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "_pend"}, 32'(pend), 32'd0);
        chk({tag, "_max_lat"}, 32'(max_lat), 32'd0);
    endtask

    initial begin
        rst_l     = 1'b0;
        enable    = 1'b1;
        max_wait  = 12'd20;
        nukeint   = 1'b0;
        resumint  = 1'b0;
        rstint    = 1'b0;
        rstthr    = '0;
        dead_mask = '0;
        repeat (2) cyc();
        chk_reset_outs("rst0");
        rst_l = 1'b1;
        cyc();

        // Nuke thr2, DEAD sampled 7 edges later.
        strobe(1'b1, 1'b0, 1'b0, 4'b0100);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("t1_pend2", 32'(pend[2]), 32'd1);
            if (k == 6) dead_mask[2] = 1'b1;
            cyc();
        end
        @(negedge clk);
        chk("t1_pend", 32'(pend), 32'd0);
        chk("t1_max_lat", 32'(max_lat), 32'd7);
        dead_mask = '0;
        cyc();

        // Nuke thr0, never DEAD, timeout 10.
        max_wait = 12'd10;
        exp_q.push_back({2'd0, 1'b0});
        strobe(1'b1, 1'b0, 1'b0, 4'b0001);
        repeat (14) cyc();
        chk("t2_sticky", 32'(err_sticky), 32'h1);
        chk("t2_err_cnt", 32'(err_cnt), 32'd1);
        chk("t2_pend", 32'(pend), 32'd0);

        // Nuke thr1, resume 3 cycles later while live: cancelled.
        strobe(1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (2) cyc();
        strobe(1'b0, 1'b1, 1'b0, 4'b0010);
        chk("t3_pend", 32'(pend), 32'd0);
        repeat (14) cyc();
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);

        // Resume thr3 while DEAD, stays DEAD, timeout 5.
        max_wait     = 12'd5;
        dead_mask[3] = 1'b1;
        exp_q.push_back({2'd3, 1'b1});
        strobe(1'b0, 1'b1, 1'b0, 4'b1000);
        chk("t4_pend", 32'(pend), 32'h8);
        repeat (8) cyc();
        dead_mask = '0;
        chk("t4_sticky", 32'(err_sticky), 32'h9);
        chk("t4_err_cnt", 32'(err_cnt), 32'd2);
        chk("t4_max_lat", 32'(max_lat), 32'd7);

        // Reset, then thr0 and thr2 saturate and time out on the same edge.
        rst_l = 1'b0;
        cyc();
        chk_reset_outs("rst1");
        rst_l    = 1'b1;
        max_wait = '0;
        cyc();
        strobe(1'b1, 1'b0, 1'b0, 4'b0100);
        strobe(1'b1, 1'b0, 1'b0, 4'b1101);
        chk("t5_pend_start", 32'(pend), 32'h5);
        repeat (4100) cyc();
        chk("t5_pend_sat", 32'(pend), 32'h5);
        chk("t5_cnt_pre", 32'(err_cnt), 32'd0);
        exp_q.push_back({2'd0, 1'b0});
        max_wait = 12'hFFF;
        repeat (3) cyc();
        chk("t5_err_cnt", 32'(err_cnt), 32'd2);
        chk("t5_sticky", 32'(err_sticky), 32'h5);
        chk("t5_pend", 32'(pend), 32'd0);

        // Async reset mid-wait, then disabled timeouts and no-target strobes.
        max_wait = 12'd10;
        strobe(1'b1, 1'b0, 1'b0, 4'b0010);
        repeat (3) cyc();
        rst_l = 1'b0;
        #2;
        chk_reset_outs("rst2");
        @(posedge clk);
        #1;
        rst_l    = 1'b1;
        enable   = 1'b0;
        max_wait = 12'd3;
        strobe(1'b1, 1'b0, 1'b0, 4'b0001);
        chk("t6_pend_dis", 32'(pend), 32'h1);
        repeat (5) cyc();
        chk("t6_pend_done", 32'(pend), 32'd0);
        chk("t6_err_cnt", 32'(err_cnt), 32'd0);
        chk("t6_sticky", 32'(err_sticky), 32'd0);
        strobe(1'b1, 1'b1, 1'b0, 4'b0000);
        chk("t6_notgt_pend", 32'(pend), 32'd0);
        repeat (3) cyc();
        chk("t6_err_vld", 32'(err_vld), 32'd0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
